// File: rtl/mmio_uart_responder.sv
// Memory-mapped UART responder: status, rx/tx byte FIFOs and free-running cycle and
// retired-instruction counters behind a small word-addressed register window.

module mmio_uart_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_s;
    logic          pop_s;

    assign empty  = (count_r == {CW{1'b0}});
    assign full   = (count_r == FULL_CNT);
    assign head   = mem_r[rd_ptr_r];
    // A push into a full FIFO is refused even if a pop happens in the same cycle.
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= push_data;
    end
endmodule

module mmio_uart_responder #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        inst_retire,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    logic [31:0] cycle_cnt_r;
    logic [31:0] inst_cnt_r;
    logic        tx_drop_r;

    logic        in_win_s;
    logic [2:0]  idx_s;
    logic        rd_status_s;
    logic        rd_rx_s;
    logic        wr_tx_s;
    logic        wr_clr_s;
    logic        tx_drop_set_s;
    logic [31:0] rd_mux_s;
    logic [31:0] status_s;
    logic [7:0]  rx_head_s;
    logic        rx_empty_s;
    logic        rx_full_s;
    logic        tx_empty_s;
    logic        tx_full_s;
    logic        unused_s;

    // The window is 32 bytes; MMIO_BASE is expected to be 32-byte aligned.
    assign in_win_s      = (addr[31:5] == MMIO_BASE[31:5]);
    assign idx_s         = addr[4:2];
    assign rd_status_s   = re && in_win_s && (idx_s == 3'd0);
    assign rd_rx_s       = re && in_win_s && (idx_s == 3'd1);
    assign wr_tx_s       = we && in_win_s && (idx_s == 3'd2);
    assign wr_clr_s      = we && in_win_s && (idx_s == 3'd6);
    assign tx_drop_set_s = wr_tx_s && tx_full_s;
    assign status_s      = {29'd0, tx_drop_r, !rx_empty_s, !tx_full_s};
    assign rx_ready      = !rx_full_s;
    assign tx_valid      = !tx_empty_s;
    assign unused_s      = ^{addr[1:0], wdata[31:8]};

    mmio_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_valid && !rx_full_s),
        .push_data (rx_data),
        .pop       (rd_rx_s),
        .head      (rx_head_s),
        .empty     (rx_empty_s),
        .full      (rx_full_s)
    );

    mmio_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_tx_s),
        .push_data (wdata[7:0]),
        .pop       (tx_ready),
        .head      (tx_data),
        .empty     (tx_empty_s),
        .full      (tx_full_s)
    );

    // Load data selection; unmapped and write-only offsets read as zero.
    always_comb begin
        rd_mux_s = 32'd0;
        if (in_win_s) begin
            case (idx_s)
                3'd0:    rd_mux_s = status_s;
                3'd1:    rd_mux_s = rx_empty_s ? 32'd0 : {24'd0, rx_head_s};
                3'd4:    rd_mux_s = cycle_cnt_r;
                3'd5:    rd_mux_s = inst_cnt_r;
                default: rd_mux_s = 32'd0;
            endcase
        end else begin
            rd_mux_s = 32'd0;
        end
    end

    // Registered load data, held between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 32'd0;
        end else if (re) begin
            rdata <= rd_mux_s;
        end
    end

    // Sticky drop flag; a drop in the same cycle as a status read wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_drop_r <= 1'b0;
        end else if (tx_drop_set_s) begin
            tx_drop_r <= 1'b1;
        end else if (rd_status_s) begin
            tx_drop_r <= 1'b0;
        end
    end

    // Cycle and retired-instruction counters; the clear write overrides increments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_r <= 32'd0;
            inst_cnt_r  <= 32'd0;
        end else if (wr_clr_s) begin
            cycle_cnt_r <= 32'd0;
            inst_cnt_r  <= 32'd0;
        end else begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
            if (inst_retire) inst_cnt_r <= inst_cnt_r + 32'd1;
        end
    end
endmodule

// File: tb/tb_mmio_uart_responder.sv
// Directed self-checking bench for mmio_uart_responder with hand-computed expectations.

module tb_mmio_uart_responder;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = 32'd0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        inst_retire = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    mmio_uart_responder #(.FIFO_DEPTH(8), .MMIO_BASE(BASE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .re          (re),
        .we          (we),
        .wdata       (wdata),
        .rdata       (rdata),
        .inst_retire (inst_retire),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Both tasks are entered just after a falling edge.
    task automatic mmio_read(input logic [31:0] off, output logic [31:0] d);
        re   = 1'b1;
        addr = BASE + off;
        @(negedge clk);
        re = 1'b0;
        d  = rdata;
    endtask

    task automatic mmio_write(input logic [31:0] off, input logic [31:0] d);
        we    = 1'b1;
        addr  = BASE + off;
        wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    logic [31:0] d;
    int          acc;
    int          ntx;
    logic [7:0]  txq [$];

    initial begin
        // Reset state
        #12;
        check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check_eq("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mmio_read(32'h00, d); check_eq("status_idle", d, 32'h1);

        // Basic rx path
        rx_valid = 1'b1; rx_data = 8'h41;
        @(negedge clk); rx_data = 8'h42;
        @(negedge clk); rx_valid = 1'b0;
        mmio_read(32'h00, d); check_eq("status_rx", d, 32'h3);
        mmio_read(32'h04, d); check_eq("rx_first", d, 32'h41);
        mmio_read(32'h04, d); check_eq("rx_second", d, 32'h42);
        mmio_read(32'h04, d); check_eq("rx_empty_read", d, 32'h0);
        mmio_read(32'h00, d); check_eq("status_rx_drained", d, 32'h1);

        // Unmapped / write-only / out-of-window reads, write to read-only status
        mmio_read(32'h0C, d); check_eq("unmapped_0c", d, 32'h0);
        mmio_read(32'h08, d); check_eq("wo_tx_read", d, 32'h0);
        mmio_read(32'h1C, d); check_eq("unmapped_1c", d, 32'h0);
        mmio_write(32'h00, 32'hFFFF_FFFF);
        mmio_read(32'h00, d); check_eq("status_ro", d, 32'h1);
        mmio_read(32'h0000_0000 - BASE + 32'h10, d); check_eq("out_of_window", d, 32'h0);

        // rx back-pressure
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h10 + 8'(acc);
            if (rx_ready) acc++;
            @(negedge clk);
        end
        check_eq("rx_accepts", acc, 32'd8);
        check_eq("rx_ready_full", {31'd0, rx_ready}, 32'd0);
        rx_data = 8'h18;
        mmio_read(32'h04, d); check_eq("rx_full_head", d, 32'h10);
        check_eq("rx_ready_reopen", {31'd0, rx_ready}, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mmio_read(32'h04, d); check_eq("rx_drain", d, 32'h11 + 32'(i));
        end
        mmio_read(32'h00, d); check_eq("status_rx_drained2", d, 32'h1);

        // tx overflow and drop flag
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) mmio_write(32'h08, 32'hAB00 + 32'(i));
        check_eq("tx_valid_full", {31'd0, tx_valid}, 32'd1);
        mmio_read(32'h00, d); check_eq("status_drop", d, 32'h4);
        mmio_read(32'h00, d); check_eq("status_drop_clr", d, 32'h0);
        tx_ready = 1'b1;
        ntx = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid) txq.push_back(tx_data);
            @(negedge clk);
        end
        tx_ready = 1'b0;
        ntx = txq.size();
        check_eq("tx_count", ntx, 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < ntx) check_eq("tx_order", {24'd0, txq[i]}, 32'(i));
        end
        mmio_read(32'h00, d); check_eq("status_tx_empty", d, 32'h1);

        // Counters
        mmio_write(32'h18, 32'h0);
        for (int i = 0; i < 100; i++) begin
            inst_retire = (i < 37);
            @(negedge clk);
        end
        inst_retire = 1'b0;
        mmio_read(32'h14, d); check_eq("inst_cnt", d, 32'd37);
        mmio_read(32'h10, d); check_eq("cycle_cnt", d, 32'd101);
        mmio_write(32'h18, 32'h0);
        mmio_read(32'h10, d); check_eq("cycle_small", {31'd0, d < 32'd4}, 32'd1);
        mmio_read(32'h14, d); check_eq("inst_cleared", d, 32'd0);

        // Cycle counter wrap
        force dut.cycle_cnt_r = 32'hFFFF_FFFE;
        #1 release dut.cycle_cnt_r;
        @(negedge clk);
        @(negedge clk);
        mmio_read(32'h10, d); check_eq("cycle_wrap", d, 32'd0);

        // Asynchronous reset with both FIFOs half full
        for (int i = 0; i < 4; i++) mmio_write(32'h08, 32'h60 + 32'(i));
        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'h70 + 8'(i);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        mmio_read(32'h00, d); check_eq("status_half", d, 32'h3);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("arst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check_eq("arst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_rdata", rdata, 32'd0);
        check_eq("post_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        mmio_read(32'h00, d); check_eq("post_rst_status", d, 32'h1);
        mmio_read(32'h04, d); check_eq("post_rst_rx", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mmio_uart_responder.md
MMIO_UART_RESPONDER -- requirements
Module: mmio_uart_responder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: entries per FIFO; power of two, minimum 2.
REQ-002 SHALL have parameter MMIO_BASE, default 32'h8000_0000: base of the register window.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port addr, input, 32 bits: CPU byte address; addr[1:0] ignored.
REQ-006 SHALL have port re, input, 1 bit: load strobe.
REQ-007 SHALL have port we, input, 1 bit: store strobe.
REQ-008 SHALL have port wdata, input, 32 bits: store data.
REQ-009 SHALL have port rdata, output, 32 bits: registered load data.
REQ-010 SHALL have port inst_retire, input, 1 bit: one instruction retired this cycle.
REQ-011 SHALL have port rx_data, input, 8 bits: byte from the UART receiver.
REQ-012 SHALL have port rx_valid, input, 1 bit: rx_data valid.
REQ-013 SHALL have port rx_ready, output, 1 bit: responder accepts rx_data.
REQ-014 SHALL have port tx_data, output, 8 bits: byte to the UART transmitter.
REQ-015 SHALL have port tx_valid, output, 1 bit: tx_data valid.
REQ-016 SHALL have port tx_ready, input, 1 bit: transmitter accepts tx_data.

Function
REQ-017 SHALL decode these word offsets from MMIO_BASE:
- 0x00: status, read-only; bit0 = tx FIFO not full, bit1 = rx FIFO not empty, bit2 = tx_drop sticky, bits 31:3 = 0.
- 0x04: rx data, read; returns {24'b0, head byte}.
- 0x08: tx data, write; wdata[7:0].
- 0x10: cycle counter, read.
- 0x14: retired-instruction counter, read.
- 0x18: counter reset, write; data ignored.
REQ-018 SHALL present rdata exactly one cycle after re, and SHALL hold rdata until the next re.
REQ-019 SHALL return 0 for a read of an unmapped or write-only offset, and SHALL ignore a write to an unmapped or read-only offset.
REQ-020 SHALL pop the rx FIFO on a read of 0x04 when it is not empty; when it is empty, the read returns 0 and no pop occurs.
REQ-021 SHALL push wdata[7:0] into the tx FIFO on a write to 0x08 when it is not full; when it is full, the byte is dropped and tx_drop sets.
REQ-022 SHALL clear tx_drop on a read of status; the returned rdata shows the pre-clear value; a drop in the same cycle wins and leaves tx_drop set.
REQ-023 SHALL drive rx_ready = rx FIFO not full, and SHALL push rx_data when rx_valid && rx_ready.
REQ-024 SHALL implement the tx FIFO as show-ahead: tx_valid = not empty, tx_data = head byte, pop when tx_valid && tx_ready.
REQ-025 SHALL hold each FIFO's occupancy count at $clog2(FIFO_DEPTH)+1 bits, with read and write pointers that wrap modulo FIFO_DEPTH.
REQ-026 SHALL let a simultaneous push and pop on a non-empty, non-full FIFO leave occupancy unchanged.
REQ-027 SHALL treat a pop on an empty FIFO as a no-op even if a push occurs in the same cycle; the pushed byte becomes the head the next cycle.
REQ-028 SHALL make a pushed byte visible (status bit1 for rx, tx_valid for tx) the cycle after the push.
REQ-029 SHALL increment the cycle counter every cycle, and the instruction counter when inst_retire = 1; both are 32 bits and wrap from 0xFFFF_FFFF to 0.
REQ-030 SHALL make a write to 0x18 zero both counters on the next edge, overriding that cycle's increment.
REQ-031 SHALL perform re and we in the same cycle independently; a counter read concurrent with a 0x18 write returns the pre-clear value.

Reset
REQ-032 SHALL, while rst_n = 0 and regardless of clk, hold both FIFOs empty, both counters at 0, tx_drop at 0, rdata at 0, tx_valid at 0 and rx_ready at 1.
REQ-033 SHALL discard all FIFO contents when reset is asserted mid-transfer, and SHALL start from the REQ-032 state on the first edge after rst_n rises.

Verification
REQ-034 SHALL be checked with: push rx 0x41, 0x42 -> status reads 0x3; rx reads return 0x41 then 0x42; a third read returns 0 and status reads 0x1.
REQ-035 SHALL be checked with: tx_ready = 0, write 9 bytes 0x00..0x08 (FIFO_DEPTH = 8) -> status bit0 = 0, bit2 = 1; next status read returns 0x4 and bit2 is then 0; with tx_ready = 1, tx_data emits 0x00..0x07 in order and byte 0x08 is absent.
REQ-036 SHALL be checked with: rx_valid held high for 10 bytes with no reads -> rx_ready falls after the 8th accept; reading one byte raises rx_ready the next cycle and the 9th byte is accepted.
REQ-037 SHALL be checked with: 100 cycles after reset with inst_retire high on 37 of them -> 0x14 reads 37; write 0x18 -> next read of 0x10 returns a small value (< 4) and 0x14 returns 0.
REQ-038 SHALL be checked with: the cycle counter preloaded near wrap (force) to 0xFFFF_FFFE -> it reads 0 two cycles later.
REQ-039 SHALL be checked with: rst_n pulsed low asynchronously between clock edges while both FIFOs are half full -> tx_valid = 0 immediately, status reads 0x1 after release, and rdata = 0.
